// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and constants for the SDRAM CPU-port arbiter
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SETTLE,
        ARB_WAIT,
        ARB_RECOVER
    } arb_state_t;

    localparam int TO_W = 8;

endpackage

// File: rtl/sdram_port_arbiter_rr_pick.sv
// rtl/sdram_port_arbiter_rr_pick.sv - combinational winner select: optional strict requester 0, else round-robin
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          prio0,
    output logic [N-1:0]  win_oh,
    output logic [IW-1:0] win_idx,
    output logic          win_any
);

    int c;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_any = 1'b0;
        c       = 0;
        if (prio0 && req[0]) begin
            win_oh[0] = 1'b1;
            win_any   = 1'b1;
        end
        // Search starts just after the last owner, so the pointer's own index comes last.
        for (int k = 1; k <= N; k++) begin
            c = int'(ptr) + k;
            if (c >= N) c = c - N;
            if (!win_any && req[c]) begin
                win_oh[c] = 1'b1;
                win_idx   = IW'(c);
                win_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - shares the SDRAM controller byte port between NUM_REQ requesters
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int AW      = 25,
    parameter int PRIO0   = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]  req_din,
    output logic [NUM_REQ-1:0]    ack,
    output logic [7:0]            rdata,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  err,
    output logic [AW-1:0]         mem_addr,
    output logic [7:0]            mem_din,
    output logic                  mem_rd,
    output logic                  mem_we,
    input  logic                  mem_busy,
    input  logic [7:0]            mem_dout
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [7:0]          rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [AW-1:0]       mem_addr_q, mem_addr_d;
    logic [7:0]          mem_din_q, mem_din_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_we_q, mem_we_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       widx_q, widx_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;

    logic [NUM_REQ-1:0]  win_oh;
    logic [IW-1:0]       win_idx;
    logic                win_any;
    logic                done;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .prio0   (PRIO0 != 0),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_any (win_any)
    );

    always_comb begin
        state_d    = state_q;
        ack_d      = '0;
        grant_d    = grant_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_rd_d   = mem_rd_q;
        mem_we_d   = mem_we_q;
        ptr_d      = ptr_q;
        widx_d     = widx_q;
        cnt_d      = cnt_q;
        done       = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                // mem_busy is deliberately ignored here: it may reflect another port's activity.
                if (win_any) begin
                    grant_d    = win_oh;
                    widx_d     = win_idx;
                    mem_addr_d = req_addr[int'(win_idx)*AW +: AW];
                    mem_din_d  = req_din[int'(win_idx)*8 +: 8];
                    mem_we_d   = req_we[win_idx];
                    mem_rd_d   = !req_we[win_idx];
                    state_d    = ARB_SETTLE;
                end
            end
            ARB_SETTLE: begin
                cnt_d   = '0;
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (!mem_busy) begin
                    done = 1'b1;
                end else if (cnt_q == TO_W'(TIMEOUT)) begin
                    done  = 1'b1;
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (done) begin
                    if (!mem_we_q) rdata_d = mem_dout;
                    ack_d    = grant_q;
                    grant_d  = '0;
                    mem_rd_d = 1'b0;
                    mem_we_d = 1'b0;
                    ptr_d    = widx_q;
                    state_d  = ARB_RECOVER;
                end
            end
            ARB_RECOVER: begin
                // One idle cycle guarantees the controller sees a fresh rd/we edge next time.
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            ack_q      <= '0;
            grant_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_rd_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            ptr_q      <= '0;
            widx_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            grant_q    <= grant_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_rd_q   <= mem_rd_d;
            mem_we_q   <= mem_we_d;
            ptr_q      <= ptr_d;
            widx_q     <= widx_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ack      = ack_q;
    assign grant    = grant_q;
    assign rdata    = rdata_q;
    assign err      = err_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_rd   = mem_rd_q;
    assign mem_we   = mem_we_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - self-checking bench: instance 0 all round-robin, instance 1 with requester 0 priority
module tb_sdram_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 25;
    localparam int TO = 255;

    typedef struct {
        int         dut;
        int         idx;
        bit         we;
        logic [24:0] addr;
        logic [7:0] din;
        int         busy;
        bit         hit;
        bit         stuck;
        bit         drop;
        logic [7:0] dout;
        logic [7:0] exp_rdata;
        bit         exp_err;
    } vec_t;

    typedef struct {
        int          dut;
        int          idx;
        logic [24:0] addr;
        logic [7:0]  din;
        bit          we;
        logic [7:0]  rdata;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst      [2];
    logic [N-1:0]    req      [2];
    logic [N-1:0]    req_we   [2];
    logic [N*AW-1:0] req_addr [2];
    logic [N*8-1:0]  req_din  [2];
    logic [N-1:0]    ack      [2];
    logic [7:0]      rdata    [2];
    logic [N-1:0]    grant    [2];
    logic            err      [2];
    logic [AW-1:0]   mem_addr [2];
    logic [7:0]      mem_din  [2];
    logic            mem_rd   [2];
    logic            mem_we   [2];
    logic            mem_busy [2];
    logic [7:0]      mem_dout [2];

    // controller model state
    logic busy_q   [2] = '{1'b0, 1'b0};
    int   bcnt     [2] = '{0, 0};
    logic rd_prev  [2] = '{1'b0, 1'b0};
    logic we_prev  [2] = '{1'b0, 1'b0};
    int   rd_edges [2] = '{0, 0};
    int   busy_len [2];
    bit   hit      [2];
    bit   stuck    [2];
    logic [7:0] dout_val [2];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[7];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sdram_port_arbiter #(
            .NUM_REQ (N),
            .AW      (AW),
            .PRIO0   (g),
            .TIMEOUT (TO)
        ) u_dut (
            .clk      (clk),
            .reset    (rst[g]),
            .req      (req[g]),
            .req_we   (req_we[g]),
            .req_addr (req_addr[g]),
            .req_din  (req_din[g]),
            .ack      (ack[g]),
            .rdata    (rdata[g]),
            .grant    (grant[g]),
            .err      (err[g]),
            .mem_addr (mem_addr[g]),
            .mem_din  (mem_din[g]),
            .mem_rd   (mem_rd[g]),
            .mem_we   (mem_we[g]),
            .mem_busy (mem_busy[g]),
            .mem_dout (mem_dout[g])
        );
        assign mem_busy[g] = busy_q[g];
        assign mem_dout[g] = dout_val[g];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Busy rises one cycle after an rd/we edge and stays high busy_len cycles (forever when stuck).
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            rd_prev[d] <= mem_rd[d];
            we_prev[d] <= mem_we[d];
            if ((mem_rd[d] && !rd_prev[d]) || (mem_we[d] && !we_prev[d])) begin
                if (mem_rd[d] && !rd_prev[d]) rd_edges[d] <= rd_edges[d] + 1;
                if (!hit[d]) begin
                    busy_q[d] <= 1'b1;
                    bcnt[d]   <= busy_len[d];
                end
            end else if (busy_q[d] && !stuck[d]) begin
                if (bcnt[d] <= 1) busy_q[d] <= 1'b0;
                else bcnt[d] <= bcnt[d] - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: checks the latched command at grant and the completion at ack.
    int  gcyc  [2] = '{0, 0};
    logic [N-1:0] gprev [2] = '{'0, '0};
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst[d]) begin
                    gprev[d] = '0;
                end else begin
                    if (grant[d] != '0 && gprev[d] == '0) begin
                        gcyc[d] = cyc;
                        if (sb.size() > 0 && sb[0].dut == d) begin
                            e = sb[0];
                            chk("grant_onehot", 32'(grant[d]), 32'(1 << e.idx));
                            chk("mem_addr", 32'(mem_addr[d]), 32'(e.addr));
                            chk("mem_rdwe", {30'd0, mem_we[d], mem_rd[d]}, {30'd0, e.we, !e.we});
                            if (e.we) chk("mem_din", 32'(mem_din[d]), 32'(e.din));
                        end
                    end
                    gprev[d] = grant[d];
                    if (ack[d] != '0) begin
                        if (sb.size() == 0 || sb[0].dut != d) begin
                            chk("unexpected_ack", 32'(ack[d]), 32'd0);
                        end else begin
                            e = sb.pop_front();
                            chk("ack_onehot", 32'(ack[d]), 32'(1 << e.idx));
                            chk("rdata", 32'(rdata[d]), 32'(e.rdata));
                            chk("ack_latency", 32'(cyc - gcyc[d]), 32'(e.lat));
                            chk("ack_cycle_idle", {29'd0, mem_rd[d], mem_we[d], grant[d] != '0}, 32'd0);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_ack(input int d);
        bit got = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(negedge clk);
            #1;
            if (ack[d] != '0) got = 1'b1;
        end
        chk("ack_arrived", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_grant(input int d);
        bit got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            #1;
            if (grant[d] != '0) got = 1'b1;
        end
        chk("grant_arrived", {31'd0, got}, 32'd1);
    endtask

    task automatic push_exp(input int d, input int i, input bit we, input logic [7:0] rd, input int lat);
        exp_t e;
        e.dut   = d;
        e.idx   = i;
        e.addr  = req_addr[d][i*AW +: AW];
        e.din   = req_din[d][i*8 +: 8];
        e.we    = we;
        e.rdata = rd;
        e.lat   = lat;
        sb.push_back(e);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        int d = v.dut;
        busy_len[d] = v.busy;
        hit[d]      = v.hit;
        stuck[d]    = v.stuck;
        dout_val[d] = v.dout;
        // grant edge -> SETTLE -> first WAIT sample: hit completes there, else after busy falls.
        lat = v.hit ? 2 : (v.stuck ? TO + 2 : v.busy + 2);
        req_we[d][v.idx]             = v.we;
        req_addr[d][v.idx*AW +: AW]  = v.addr;
        req_din[d][v.idx*8 +: 8]     = v.din;
        push_exp(d, v.idx, v.we, v.exp_rdata, lat);
        req[d][v.idx] = 1'b1;
        if (v.drop) begin
            wait_grant(d);
            req[d][v.idx] = 1'b0;
        end
        wait_ack(d);
        req[d][v.idx] = 1'b0;
        chk("err", {31'd0, err[d]}, {31'd0, v.exp_err});
        stuck[d] = 1'b0;
        repeat (3) @(negedge clk);
        #1;
    endtask

    initial begin
        int e0;
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        //            dut idx we  addr        din    busy hit stk drop dout   rdata  err
        vecs[0] = '{1, 1, 0, 25'h0000123, 8'h00, 6, 0, 0, 0, 8'hA5, 8'hA5, 0};
        vecs[1] = '{1, 0, 0, 25'h00ABCDE, 8'h00, 0, 1, 0, 0, 8'h3C, 8'h3C, 0};
        vecs[2] = '{1, 2, 1, 25'h1FFFFFF, 8'h77, 3, 0, 0, 1, 8'hEE, 8'h3C, 0};
        vecs[3] = '{1, 1, 1, 25'h00000F0, 8'h5A, 1, 0, 1, 0, 8'h99, 8'h3C, 1};
        vecs[4] = '{1, 0, 0, 25'h0000042, 8'h00, 1, 0, 0, 0, 8'h81, 8'h81, 1};
        vecs[5] = '{0, 2, 0, 25'h0155555, 8'h00, 2, 0, 0, 0, 8'h11, 8'h11, 0};
        vecs[6] = '{1, 2, 0, 25'h00C0FFE, 8'h00, 4, 0, 0, 0, 8'hC3, 8'hC3, 0};

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req[d] = '0; req_we[d] = '0; req_addr[d] = '0; req_din[d] = '0;
            busy_len[d] = 1; hit[d] = 1'b0; stuck[d] = 1'b0; dout_val[d] = 8'h00;
        end
        repeat (3) @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ack", 32'(ack[d]), 32'd0);
            chk("rst_grant", 32'(grant[d]), 32'd0);
            chk("rst_rdwe_err", {29'd0, mem_rd[d], mem_we[d], err[d]}, 32'd0);
            chk("rst_data", {mem_din[d], rdata[d]}, 32'd0);
            chk("rst_addr", 32'(mem_addr[d]), 32'd0);
        end

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // All three held on the round-robin instance; last owner was 2 so order is 0,1,2,0.
        busy_len[0] = 2; hit[0] = 1'b0; dout_val[0] = 8'h66;
        req_we[0] = '0;
        req_addr[0] = {25'h0000300, 25'h0000200, 25'h0000100};
        e0 = rd_edges[0];
        push_exp(0, 0, 0, 8'h66, 4);
        push_exp(0, 1, 0, 8'h66, 4);
        push_exp(0, 2, 0, 8'h66, 4);
        push_exp(0, 0, 0, 8'h66, 4);
        req[0] = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_ack(0);
            if (k == 3) req[0] = '0;
        end
        chk("rr_rd_edges", 32'(rd_edges[0] - e0), 32'd4);
        repeat (3) @(negedge clk);

        // Priority instance: requester 0 re-requests after every ack and keeps beating requester 2.
        busy_len[1] = 2; hit[1] = 1'b0; dout_val[1] = 8'h44;
        req_we[1] = '0;
        req_addr[1] = {25'h0001002, 25'h0001001, 25'h0001000};
        for (int k = 0; k < 3; k++) push_exp(1, 0, 0, 8'h44, 4);
        push_exp(1, 2, 0, 8'h44, 4);
        req[1] = 3'b101;
        for (int k = 0; k < 4; k++) begin
            wait_ack(1);
            req[1][0] = 1'b0;
            if (k == 3) req[1] = '0;
            @(negedge clk);
            if (k < 2) req[1][0] = 1'b1;
        end
        chk("prio_err_sticky", {31'd0, err[1]}, 32'd1);
        repeat (3) @(negedge clk);

        // Reset in WAIT abandons the read silently; no expectation is queued for it.
        busy_len[1] = 10; dout_val[1] = 8'hBB;
        req_addr[1][AW +: AW] = 25'h0000777;
        req[1][1] = 1'b1;
        wait_grant(1);
        repeat (3) @(negedge clk);
        rst[1] = 1'b1;
        #1;
        req[1] = '0;
        chk("wrst_ack_grant", {ack[1], grant[1]}, 32'd0);
        chk("wrst_rdwe_err", {29'd0, mem_rd[1], mem_we[1], err[1]}, 32'd0);
        chk("wrst_data", {mem_din[1], rdata[1]}, 32'd0);
        chk("wrst_addr", 32'(mem_addr[1]), 32'd0);
        repeat (2) @(negedge clk);
        rst[1] = 1'b0;
        repeat (15) @(negedge clk);
        chk("wrst_no_pending", 32'(sb.size()), 32'd0);
        run_vec(vecs[6]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
